// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Purpose  : Multi-cycle processor control FSM. Sequences fetch, decode,
//            execute, memory and write-back steps from the 4-bit opcode and
//            decodes datapath controls from the current state.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit (
  input  logic       input_CLK,
  input  logic       input_Reset_n,
  input  logic [3:0] input_Opcode,
  input  logic       input_Zero,
  input  logic       input_Negative,
  input  logic       input_Carry,
  input  logic       input_MemReady,
  output logic [3:0] output_ALUOp,
  output logic       output_ALUSrcA,
  output logic [1:0] output_ALUSrcB,
  output logic       output_PCWrite,
  output logic       output_IRWrite,
  output logic       output_MemRead,
  output logic       output_MemWrite,
  output logic       output_RegWrite,
  output logic       output_MemToReg,
  output logic       output_RegDst,
  output logic [1:0] output_PCSource,
  output logic [3:0] output_State
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    EXEC_I    = 4'd3,
    ALU_WB    = 4'd4,
    MEM_ADDR  = 4'd5,
    MEM_READ  = 4'd6,
    MEM_WB    = 4'd7,
    MEM_WRITE = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10
  } state_t;

  localparam logic [3:0] OP_RTYPE_MAX = 4'h9;
  localparam logic [3:0] OP_ADDI      = 4'hA;
  localparam logic [3:0] OP_LW        = 4'hB;
  localparam logic [3:0] OP_SW        = 4'hC;
  localparam logic [3:0] OP_BEQ       = 4'hD;
  localparam logic [3:0] OP_BLT       = 4'hE;

  state_t     state;
  logic [3:0] op_latched;

  // The carry flag plays no part in control; tie it off explicitly.
  logic unused_carry;
  assign unused_carry = input_Carry;

  // State sequencing; opcode is captured in DECODE so later steps see a stable copy.
  always_ff @(posedge input_CLK or negedge input_Reset_n) begin
    if (!input_Reset_n) begin
      state      <= FETCH;
      op_latched <= 4'h0;
    end else begin
      case (state)
        FETCH: begin
          if (input_MemReady) state <= DECODE;
        end
        DECODE: begin
          op_latched <= input_Opcode;
          if (input_Opcode <= OP_RTYPE_MAX) begin
            state <= EXEC_R;
          end else begin
            case (input_Opcode)
              OP_ADDI:       state <= EXEC_I;
              OP_LW, OP_SW:  state <= MEM_ADDR;
              OP_BEQ, OP_BLT: state <= BRANCH;
              default:       state <= JUMP;
            endcase
          end
        end
        EXEC_R, EXEC_I: state <= ALU_WB;
        MEM_ADDR: state <= (op_latched == OP_LW) ? MEM_READ : MEM_WRITE;
        MEM_READ: begin
          if (input_MemReady) state <= MEM_WB;
        end
        MEM_WRITE: begin
          if (input_MemReady) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // State-decoded controls; everything is held low while reset is asserted.
  always_comb begin
    output_ALUOp    = 4'b0000;
    output_ALUSrcA  = 1'b0;
    output_ALUSrcB  = 2'b00;
    output_PCWrite  = 1'b0;
    output_IRWrite  = 1'b0;
    output_MemRead  = 1'b0;
    output_MemWrite = 1'b0;
    output_RegWrite = 1'b0;
    output_MemToReg = 1'b0;
    output_RegDst   = 1'b0;
    output_PCSource = 2'b00;
    if (input_Reset_n) begin
      case (state)
        FETCH: begin
          output_MemRead = 1'b1;
          output_ALUSrcB = 2'b01;
          output_IRWrite = input_MemReady;
          output_PCWrite = input_MemReady;
        end
        DECODE: begin
          output_ALUSrcB = 2'b11;
        end
        EXEC_R: begin
          output_ALUSrcA = 1'b1;
          output_ALUOp   = op_latched;
        end
        EXEC_I, MEM_ADDR: begin
          output_ALUSrcA = 1'b1;
          output_ALUSrcB = 2'b10;
        end
        ALU_WB: begin
          output_RegWrite = 1'b1;
          output_RegDst   = (op_latched <= OP_RTYPE_MAX);
        end
        MEM_READ: output_MemRead = 1'b1;
        MEM_WB: begin
          output_RegWrite = 1'b1;
          output_MemToReg = 1'b1;
        end
        MEM_WRITE: output_MemWrite = 1'b1;
        BRANCH: begin
          output_ALUSrcA  = 1'b1;
          output_ALUOp    = 4'b0001;
          output_PCSource = 2'b01;
          output_PCWrite  = (op_latched == OP_BEQ) ? input_Zero : input_Negative;
        end
        JUMP: begin
          output_PCSource = 2'b10;
          output_PCWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign output_State = state;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Self-checking bench for control_unit. Expected per-cycle control
//            vectors are built from the instruction-class step lists.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       zero = 1'b0, neg = 1'b0, carry = 1'b0, ready = 1'b0;
  logic [3:0] alu_op;
  logic       src_a;
  logic [1:0] src_b;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, reg_dst;
  logic [1:0] pc_source;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  control_unit dut (
    .input_CLK(clk), .input_Reset_n(rst_n), .input_Opcode(opcode),
    .input_Zero(zero), .input_Negative(neg), .input_Carry(carry),
    .input_MemReady(ready),
    .output_ALUOp(alu_op), .output_ALUSrcA(src_a), .output_ALUSrcB(src_b),
    .output_PCWrite(pc_write), .output_IRWrite(ir_write),
    .output_MemRead(mem_read), .output_MemWrite(mem_write),
    .output_RegWrite(reg_write), .output_MemToReg(mem_to_reg),
    .output_RegDst(reg_dst), .output_PCSource(pc_source), .output_State(state)
  );

  always #5 clk = ~clk;

  // One expected cycle: stimulus to apply plus the full control vector required.
  typedef struct {
    logic [3:0]  op;
    bit          rdy, z, n, c;
    logic [19:0] exp;
  } cyc_t;
  cyc_t q[$];

  function automatic bit rb();
    return bit'($urandom % 2);
  endfunction

  // Vector order: state, ALUOp, SrcA, SrcB, PCSource, PCWrite, IRWrite,
  // MemRead, MemWrite, RegWrite, MemToReg, RegDst
  function automatic logic [19:0] mk(input logic [3:0] st, input logic [3:0] aop,
                                     input bit sa, input logic [1:0] sb,
                                     input logic [1:0] pcs, input bit pcw, input bit irw,
                                     input bit mr, input bit mw, input bit rw,
                                     input bit m2r, input bit rd);
    return {st, aop, sa, sb, pcs, pcw, irw, mr, mw, rw, m2r, rd};
  endfunction

  function automatic logic [19:0] observed();
    return {state, alu_op, src_a, src_b, pc_source, pc_write, ir_write,
            mem_read, mem_write, reg_write, mem_to_reg, reg_dst};
  endfunction

  task automatic push(input logic [3:0] op, input bit rdy, input bit z, input bit n,
                      input logic [19:0] e);
    cyc_t t;
    t.op = op; t.rdy = rdy; t.z = z; t.n = n; t.c = rb(); t.exp = e;
    q.push_back(t);
  endtask

  // Expand one instruction into the cycles it must take and the controls of each.
  task automatic build_instr(input logic [3:0] op, input int fw, input int mwt,
                             input bit bz, input bit bn);
    for (int i = 0; i < fw; i++)
      push(op, 1'b0, rb(), rb(), mk(4'd0, 4'h0, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0));
    push(op, 1'b1, rb(), rb(), mk(4'd0, 4'h0, 0, 2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 0));
    push(op, rb(), rb(), rb(), mk(4'd1, 4'h0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    if (op <= 4'h9) begin
      push(op, rb(), rb(), rb(), mk(4'd2, op, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      push(op, rb(), rb(), rb(), mk(4'd4, 4'h0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1));
    end else if (op == 4'hA) begin
      push(op, rb(), rb(), rb(), mk(4'd3, 4'h0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      push(op, rb(), rb(), rb(), mk(4'd4, 4'h0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0));
    end else if (op == 4'hB) begin
      push(op, rb(), rb(), rb(), mk(4'd5, 4'h0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < mwt; i++)
        push(op, 1'b0, rb(), rb(), mk(4'd6, 4'h0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0));
      push(op, 1'b1, rb(), rb(), mk(4'd6, 4'h0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0));
      push(op, rb(), rb(), rb(), mk(4'd7, 4'h0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0));
    end else if (op == 4'hC) begin
      push(op, rb(), rb(), rb(), mk(4'd5, 4'h0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < mwt; i++)
        push(op, 1'b0, rb(), rb(), mk(4'd8, 4'h0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0));
      push(op, 1'b1, rb(), rb(), mk(4'd8, 4'h0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0));
    end else if (op == 4'hD || op == 4'hE) begin
      push(op, rb(), bz, bn, mk(4'd9, 4'h1, 1, 2'b00, 2'b01,
                                (op == 4'hD) ? bz : bn, 0, 0, 0, 0, 0, 0));
    end else begin
      push(op, rb(), rb(), rb(), mk(4'd10, 4'h0, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0));
    end
  endtask

  // Drive one cycle's inputs on the falling edge and sample just after.
  task automatic step(input logic [3:0] op, input bit rdy, input bit z, input bit n,
                      input bit c, output logic [19:0] obs);
    @(negedge clk);
    opcode = op; ready = rdy; zero = z; neg = n; carry = c;
    #1;
    obs = observed();
  endtask

  task automatic test_reset();
    logic [19:0] obs;
    rst_n = 1'b0; ready = 1'b1; opcode = 4'hB;
    repeat (2) @(negedge clk);
    #1;
    obs = observed();
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %05h required %05h", obs, 20'h0);
    end
    @(negedge clk);
    ready = 1'b0;
    rst_n = 1'b1;
    #1;
    obs = observed();
    checks++;
    if (obs !== mk(4'd0, 4'h0, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_release_fetch: got %05h required %05h", obs,
               mk(4'd0, 4'h0, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0));
    end
  endtask

  task automatic test_r_type();
    logic [19:0] obs;
    q.delete();
    build_instr(4'h0, 0, 0, 1'b0, 1'b0);
    build_instr(4'h7, 0, 0, 1'b0, 1'b0);
    build_instr(4'hA, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < q.size(); i++) begin
      step(q[i].op, q[i].rdy, q[i].z, q[i].n, q[i].c, obs);
      checks++;
      if (obs !== q[i].exp) begin
        errors++;
        $display("FAIL r_type[%0d]: got %05h required %05h", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [19:0] obs;
    q.delete();
    build_instr(4'hB, 0, 3, 1'b0, 1'b0);
    build_instr(4'hC, 0, 2, 1'b0, 1'b0);
    for (int i = 0; i < q.size(); i++) begin
      step(q[i].op, q[i].rdy, q[i].z, q[i].n, q[i].c, obs);
      checks++;
      if (obs !== q[i].exp) begin
        errors++;
        $display("FAIL lw_wait[%0d]: got %05h required %05h", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_branch();
    logic [19:0] obs;
    q.delete();
    build_instr(4'hD, 0, 0, 1'b1, 1'b0);
    build_instr(4'hD, 0, 0, 1'b0, 1'b1);
    build_instr(4'hE, 0, 0, 1'b0, 1'b1);
    build_instr(4'hE, 0, 0, 1'b1, 1'b0);
    build_instr(4'hF, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < q.size(); i++) begin
      step(q[i].op, q[i].rdy, q[i].z, q[i].n, q[i].c, obs);
      checks++;
      if (obs !== q[i].exp) begin
        errors++;
        $display("FAIL branch[%0d]: got %05h required %05h", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_fetch_wait();
    logic [19:0] obs;
    q.delete();
    build_instr(4'h3, 2, 0, 1'b0, 1'b0);
    build_instr(4'hF, 2, 0, 1'b0, 1'b0);
    for (int i = 0; i < q.size(); i++) begin
      step(q[i].op, q[i].rdy, q[i].z, q[i].n, q[i].c, obs);
      checks++;
      if (obs !== q[i].exp) begin
        errors++;
        $display("FAIL fetch_wait[%0d]: got %05h required %05h", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] obs;
    q.delete();
    for (int k = 0; k < 40; k++)
      build_instr(4'($urandom % 16), int'($urandom % 3), int'($urandom % 4), rb(), rb());
    for (int i = 0; i < q.size(); i++) begin
      step(q[i].op, q[i].rdy, q[i].z, q[i].n, q[i].c, obs);
      checks++;
      if (obs !== q[i].exp) begin
        errors++;
        $display("FAIL b2b[%0d]: got %05h required %05h", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [19:0] obs;
    q.delete();
    // sw: FETCH, DECODE, MEM_ADDR, then MEM_WRITE waiting; abort in first wait cycle
    build_instr(4'hC, 0, 3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(q[i].op, q[i].rdy, q[i].z, q[i].n, q[i].c, obs);
      checks++;
      if (obs !== q[i].exp) begin
        errors++;
        $display("FAIL async_pre[%0d]: got %05h required %05h", i, obs, q[i].exp);
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    obs = observed();
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL async_drop: got %05h required %05h", obs, 20'h0);
    end
    @(negedge clk);
    ready = 1'b0; opcode = 4'hF;
    #1;
    obs = observed();
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL async_hold: got %05h required %05h", obs, 20'h0);
    end
    rst_n = 1'b1;
    q.delete();
    build_instr(4'hF, 1, 0, 1'b0, 1'b0);
    for (int i = 0; i < q.size(); i++) begin
      step(q[i].op, q[i].rdy, q[i].z, q[i].n, q[i].c, obs);
      checks++;
      if (obs !== q[i].exp) begin
        errors++;
        $display("FAIL async_post[%0d]: got %05h required %05h", i, obs, q[i].exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw_wait();
    test_branch();
    test_fetch_wait();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
